// File: rtl/bldc_commutator.sv
// rtl/bldc_commutator.sv - six-step BLDC commutation sequencer with hall filter, dead time and fault latch
module bldc_commutator #(
    parameter int DUTY_CYCLE_WIDTH = 10,
    parameter int HALL_FILTER      = 4,
    parameter int DEAD_TIME        = 16,
    parameter int STALL_WIDTH      = 20
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        direction,
    input  logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
    input  logic [2:0]                  hall,
    input  logic                        fault_clear,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_a,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_b,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_c,
    output logic                        high_z_a,
    output logic                        high_z_b,
    output logic                        high_z_c,
    output logic                        commutate,
    output logic                        fault,
    output logic [1:0]                  state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEAD  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Phase indices; PH_NONE marks "no phase" for invalid hall codes.
    localparam logic [1:0] PH_A    = 2'd0;
    localparam logic [1:0] PH_B    = 2'd1;
    localparam logic [1:0] PH_C    = 2'd2;
    localparam logic [1:0] PH_NONE = 2'd3;

    localparam logic [3:0]             FILT_LEN  = 4'(HALL_FILTER);
    localparam logic [7:0]             DEAD_LOAD = 8'(DEAD_TIME);
    localparam logic [STALL_WIDTH-1:0] STALL_MAX = '1;

    // Returns {pwm_phase, low_phase}; reverse simply swaps the two roles.
    function automatic logic [3:0] role_sel(input logic [2:0] code, input logic dir);
        logic [1:0] pwm;
        logic [1:0] low;
        case (code)
            3'b101:  begin pwm = PH_A; low = PH_B; end
            3'b100:  begin pwm = PH_A; low = PH_C; end
            3'b110:  begin pwm = PH_B; low = PH_C; end
            3'b010:  begin pwm = PH_B; low = PH_A; end
            3'b011:  begin pwm = PH_C; low = PH_A; end
            3'b001:  begin pwm = PH_C; low = PH_B; end
            default: begin pwm = PH_NONE; low = PH_NONE; end
        endcase
        return dir ? {low, pwm} : {pwm, low};
    endfunction

    logic [2:0]                  hall_s1_q, hall_s1_d;
    logic [2:0]                  hall_s2_q, hall_s2_d;
    logic [2:0]                  hall_cand_q, hall_cand_d;
    logic [3:0]                  filt_cnt_q, filt_cnt_d;
    logic [2:0]                  hall_filt_q, hall_filt_d;
    state_t                      state_q, state_d;
    logic [7:0]                  dead_cnt_q, dead_cnt_d;
    logic [STALL_WIDTH-1:0]      stall_q, stall_d;
    logic [STALL_WIDTH-1:0]      stall_next;
    logic [2:0]                  role_hall_q, role_hall_d;
    logic                        role_dir_q, role_dir_d;
    logic                        commutate_q, commutate_d;
    logic                        fault_q, fault_d;
    logic [DUTY_CYCLE_WIDTH-1:0] duty_a_q, duty_a_d;
    logic [DUTY_CYCLE_WIDTH-1:0] duty_b_q, duty_b_d;
    logic [DUTY_CYCLE_WIDTH-1:0] duty_c_q, duty_c_d;
    logic                        high_z_a_q, high_z_a_d;
    logic                        high_z_b_q, high_z_b_d;
    logic                        high_z_c_q, high_z_c_d;
    logic                        hall_valid;
    logic                        drive_next;
    logic [1:0]                  role_pwm;
    logic [1:0]                  role_low;

    // Hall synchronizer and run-length filter: accept a new code once it has been stable long enough.
    always_comb begin
        hall_s1_d   = hall;
        hall_s2_d   = hall_s1_q;
        hall_cand_d = hall_s2_q;
        hall_filt_d = hall_filt_q;
        if (hall_s2_q == hall_cand_q) begin
            filt_cnt_d = (filt_cnt_q == 4'hF) ? filt_cnt_q : filt_cnt_q + 4'd1;
        end else begin
            filt_cnt_d = 4'd1;
        end
        if ((hall_s2_q != hall_filt_q) && (filt_cnt_d >= FILT_LEN)) begin
            hall_filt_d = hall_s2_q;
        end
    end

    assign hall_valid = (hall_filt_q != 3'b000) && (hall_filt_q != 3'b111);

    // Stall counter candidate value: cleared by zero duty, saturating otherwise.
    always_comb begin
        stall_next = '0;
        if (duty_cycle != '0) begin
            stall_next = (stall_q == STALL_MAX) ? stall_q : stall_q + 1'b1;
        end
    end

    // Sequencer next state; fault conditions outrank enable, which outranks commutation.
    always_comb begin
        state_d     = state_q;
        dead_cnt_d  = dead_cnt_q;
        stall_d     = stall_q;
        role_hall_d = role_hall_q;
        role_dir_d  = role_dir_q;
        commutate_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && hall_valid) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = DEAD_LOAD;
                end
            end
            ST_DEAD: begin
                if (!hall_valid) begin
                    state_d = ST_FAULT;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    dead_cnt_d = dead_cnt_q - 8'd1;
                    if (dead_cnt_q == 8'd1) begin
                        state_d     = ST_DRIVE;
                        role_hall_d = hall_filt_q;
                        role_dir_d  = direction;
                        stall_d     = '0;
                    end
                end
            end
            ST_DRIVE: begin
                stall_d = stall_next;
                if (!hall_valid || (stall_next == STALL_MAX)) begin
                    state_d = ST_FAULT;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else if ((hall_filt_q != role_hall_q) || (direction != role_dir_q)) begin
                    state_d     = ST_DEAD;
                    dead_cnt_d  = DEAD_LOAD;
                    commutate_d = 1'b1;
                end
            end
            default: begin
                if (fault_clear && !enable) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Phase driver outputs for the coming cycle; only DRIVE ever un-floats a phase.
    always_comb begin
        {role_pwm, role_low} = role_sel(role_hall_d, role_dir_d);
        drive_next = (state_d == ST_DRIVE);
        fault_d    = (state_d == ST_FAULT);
        duty_a_d   = (drive_next && (role_pwm == PH_A)) ? duty_cycle : '0;
        duty_b_d   = (drive_next && (role_pwm == PH_B)) ? duty_cycle : '0;
        duty_c_d   = (drive_next && (role_pwm == PH_C)) ? duty_cycle : '0;
        high_z_a_d = !(drive_next && ((role_pwm == PH_A) || (role_low == PH_A)));
        high_z_b_d = !(drive_next && ((role_pwm == PH_B) || (role_low == PH_B)));
        high_z_c_d = !(drive_next && ((role_pwm == PH_C) || (role_low == PH_C)));
    end

    // State and output registers; reset floats every phase immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hall_s1_q   <= 3'b000;
            hall_s2_q   <= 3'b000;
            hall_cand_q <= 3'b000;
            filt_cnt_q  <= 4'd0;
            hall_filt_q <= 3'b000;
            state_q     <= ST_IDLE;
            dead_cnt_q  <= 8'd0;
            stall_q     <= '0;
            role_hall_q <= 3'b000;
            role_dir_q  <= 1'b0;
            commutate_q <= 1'b0;
            fault_q     <= 1'b0;
            duty_a_q    <= '0;
            duty_b_q    <= '0;
            duty_c_q    <= '0;
            high_z_a_q  <= 1'b1;
            high_z_b_q  <= 1'b1;
            high_z_c_q  <= 1'b1;
        end else begin
            hall_s1_q   <= hall_s1_d;
            hall_s2_q   <= hall_s2_d;
            hall_cand_q <= hall_cand_d;
            filt_cnt_q  <= filt_cnt_d;
            hall_filt_q <= hall_filt_d;
            state_q     <= state_d;
            dead_cnt_q  <= dead_cnt_d;
            stall_q     <= stall_d;
            role_hall_q <= role_hall_d;
            role_dir_q  <= role_dir_d;
            commutate_q <= commutate_d;
            fault_q     <= fault_d;
            duty_a_q    <= duty_a_d;
            duty_b_q    <= duty_b_d;
            duty_c_q    <= duty_c_d;
            high_z_a_q  <= high_z_a_d;
            high_z_b_q  <= high_z_b_d;
            high_z_c_q  <= high_z_c_d;
        end
    end

    assign duty_a    = duty_a_q;
    assign duty_b    = duty_b_q;
    assign duty_c    = duty_c_q;
    assign high_z_a  = high_z_a_q;
    assign high_z_b  = high_z_b_q;
    assign high_z_c  = high_z_c_q;
    assign commutate = commutate_q;
    assign fault     = fault_q;
    assign state     = state_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// tb/tb_bldc_commutator.sv - randomized self-checking bench for bldc_commutator against a reference model
module tb_bldc_commutator;

    localparam int DW = 10;
    localparam int HF = 4;
    localparam int DT = 16;
    localparam int SW = 8;
    localparam logic [3*DW+6:0] RESET_VEC = {30'd0, 3'b111, 1'b0, 1'b0, 2'd0};

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          direction = 1'b0;
    logic [DW-1:0] duty_cycle = '0;
    logic [2:0]    hall = 3'b000;
    logic          fault_clear = 1'b0;
    logic [DW-1:0] duty_a, duty_b, duty_c;
    logic          high_z_a, high_z_b, high_z_c;
    logic          commutate, fault;
    logic [1:0]    state;

    int n_tests = 0;
    int n_fail  = 0;

    bldc_commutator #(
        .DUTY_CYCLE_WIDTH(DW),
        .HALL_FILTER(HF),
        .DEAD_TIME(DT),
        .STALL_WIDTH(SW)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .direction(direction),
        .duty_cycle(duty_cycle),
        .hall(hall),
        .fault_clear(fault_clear),
        .duty_a(duty_a),
        .duty_b(duty_b),
        .duty_c(duty_c),
        .high_z_a(high_z_a),
        .high_z_b(high_z_b),
        .high_z_c(high_z_c),
        .commutate(commutate),
        .fault(fault),
        .state(state)
    );

    always #5 clock = ~clock;

    logic [3*DW+6:0] dut_vec;
    assign dut_vec = {duty_a, duty_b, duty_c, high_z_a, high_z_b, high_z_c, commutate, fault, state};

    // Reference model: phase roles from the six-step table, states 0..3 as named in the port list.
    typedef struct packed {
        logic [1:0] st;
        logic [7:0] dead;
        logic [7:0] stall;
        logic [2:0] filt;
        logic [2:0] rh;
        logic       rd;
        logic       cm;
    } m_t;

    m_t                  m;
    logic [3*(HF+1)-1:0] m_hist;
    logic [3*DW+6:0]     exp_vec;

    function automatic int pwm_phase(input logic [2:0] c);
        case (c)
            3'b101, 3'b100: return 0;
            3'b110, 3'b010: return 1;
            3'b011, 3'b001: return 2;
            default:        return 0;
        endcase
    endfunction

    function automatic int low_phase(input logic [2:0] c);
        case (c)
            3'b010, 3'b011: return 0;
            3'b101, 3'b001: return 1;
            3'b100, 3'b110: return 2;
            default:        return 1;
        endcase
    endfunction

    function automatic m_t model_next(input m_t cur, input logic [3*(HF+1)-1:0] hist, input logic en,
                                      input logic dir, input logic fc, input logic [DW-1:0] duty);
        m_t   n;
        logic hv;
        logic stable;
        n    = cur;
        n.cm = 1'b0;
        hv   = (cur.filt != 3'b000) && (cur.filt != 3'b111);
        case (cur.st)
            2'd0: if (en && hv) begin n.st = 2'd1; n.dead = 8'(DT); end
            2'd1: begin
                if (!hv) n.st = 2'd3;
                else if (!en) n.st = 2'd0;
                else begin
                    n.dead = cur.dead - 8'd1;
                    if (n.dead == 8'd0) begin
                        n.st = 2'd2; n.rh = cur.filt; n.rd = dir; n.stall = 8'd0;
                    end
                end
            end
            2'd2: begin
                if (duty == '0) n.stall = 8'd0;
                else if (cur.stall != 8'hFF) n.stall = cur.stall + 8'd1;
                if (!hv || n.stall == 8'hFF) n.st = 2'd3;
                else if (!en) n.st = 2'd0;
                else if (cur.filt != cur.rh || dir != cur.rd) begin
                    n.st = 2'd1; n.dead = 8'(DT); n.cm = 1'b1;
                end
            end
            default: if (fc && !en) n.st = 2'd0;
        endcase
        // hist[i] holds the raw hall from i+1 edges ago; entries 1..HF are the last HF synchronized samples.
        stable = 1'b1;
        for (int i = 2; i <= HF; i++) if (hist[3*i +: 3] != hist[3 +: 3]) stable = 1'b0;
        if (stable && hist[3 +: 3] != cur.filt) n.filt = hist[3 +: 3];
        return n;
    endfunction

    function automatic logic [3*DW+6:0] model_outs(input m_t n, input logic [DW-1:0] duty);
        logic [DW-1:0] pd [0:2];
        logic          hz [0:2];
        int            p, l;
        for (int i = 0; i < 3; i++) begin pd[i] = '0; hz[i] = 1'b1; end
        if (n.st == 2'd2) begin
            p = n.rd ? low_phase(n.rh) : pwm_phase(n.rh);
            l = n.rd ? pwm_phase(n.rh) : low_phase(n.rh);
            pd[p] = duty; hz[p] = 1'b0; hz[l] = 1'b0;
        end
        return {pd[0], pd[1], pd[2], hz[0], hz[1], hz[2], n.cm, (n.st == 2'd3), n.st};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m       <= '0;
            m_hist  <= '0;
            exp_vec <= RESET_VEC;
        end else begin
            m       <= model_next(m, m_hist, enable, direction, fault_clear, duty_cycle);
            exp_vec <= model_outs(model_next(m, m_hist, enable, direction, fault_clear, duty_cycle), duty_cycle);
            m_hist  <= {m_hist[3*HF-1:0], hall};
        end
    end

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; direction = 1'b0; duty_cycle = '0; hall = 3'b000; fault_clear = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++;
        if (dut_vec !== RESET_VEC) begin n_fail++; $display("FAIL reset_vals got=%h exp=%h", dut_vec, RESET_VEC); end
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        n_tests++;
        if (dut_vec !== exp_vec || state !== 2'd0) begin n_fail++; $display("FAIL reset_idle got=%h exp=%h", dut_vec, exp_vec); end
    endtask

    task automatic test_startup();
        int exp_st;
        hall = 3'b101; enable = 1'b1; direction = 1'b0; duty_cycle = 10'd512;
        for (int c = 1; c <= 23; c++) begin
            @(negedge clock);
            exp_st = (c < 2 + HF + 1) ? 0 : ((c < 2 + HF + 1 + DT) ? 1 : 2);
            n_tests++;
            if (dut_vec !== exp_vec || state !== 2'(exp_st)) begin
                n_fail++; $display("FAIL startup c=%0d state=%0d exp_state=%0d got=%h exp=%h", c, state, exp_st, dut_vec, exp_vec);
            end
        end
        n_tests++;
        if (duty_a !== 10'd512 || high_z_a !== 1'b0 || duty_b !== 10'd0 || high_z_b !== 1'b0 || high_z_c !== 1'b1) begin
            n_fail++; $display("FAIL startup_roles got a=%0d/%b b=%0d/%b c_hz=%b exp 512/0 0/0 1", duty_a, high_z_a, duty_b, high_z_b, high_z_c);
        end
    endtask

    task automatic test_walk(input logic dir);
        logic [2:0]    seq [0:5];
        logic [2:0]    code;
        logic          prev_dir;
        int            comm_n, float_n, exp_comm, p, l, f;
        logic [DW-1:0] dv [0:2];
        logic          hz [0:2];
        seq = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
        prev_dir = direction;
        for (int s = 0; s < 7; s++) begin
            if (s == 0) begin
                direction = dir; code = hall; exp_comm = (dir != prev_dir) ? 1 : 0;
            end else begin
                code = seq[s-1]; hall = code; exp_comm = 1;
            end
            comm_n = 0; float_n = 0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clock);
                n_tests++;
                if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL walk s=%0d c=%0d got=%h exp=%h", s, c, dut_vec, exp_vec); end
                if (commutate) comm_n++;
                if ({high_z_a, high_z_b, high_z_c} == 3'b111) float_n++;
                if ($urandom_range(0, 15) == 0) duty_cycle = DW'($urandom_range(1, 1023));
            end
            n_tests++;
            if (comm_n != exp_comm || float_n != exp_comm * DT) begin
                n_fail++; $display("FAIL walk_dead s=%0d commutates=%0d exp=%0d float_cycles=%0d exp=%0d", s, comm_n, exp_comm, float_n, exp_comm * DT);
            end
            p = dir ? low_phase(code) : pwm_phase(code);
            l = dir ? pwm_phase(code) : low_phase(code);
            f = 3 - p - l;
            dv = '{duty_a, duty_b, duty_c};
            hz = '{high_z_a, high_z_b, high_z_c};
            n_tests++;
            if (hz[p] !== 1'b0 || hz[l] !== 1'b0 || hz[f] !== 1'b1 || dv[p] !== duty_cycle || dv[l] !== '0 || dv[f] !== '0) begin
                n_fail++; $display("FAIL walk_roles code=%b dir=%b got=%h pwm=%0d low=%0d duty=%0d", code, dir, dut_vec, p, l, duty_cycle);
            end
        end
    endtask

    task automatic test_glitch_fault();
        int bad;
        hall = 3'b111;
        repeat (2) @(negedge clock);
        hall = 3'b101;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            n_tests++;
            if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL glitch c=%0d got=%h exp=%h", c, dut_vec, exp_vec); end
            if (state !== 2'd2 || commutate !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL glitch_ignored disturbed_cycles=%0d exp=0", bad); end
        hall = 3'b111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            n_tests++;
            if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL invalid_hall c=%0d got=%h exp=%h", c, dut_vec, exp_vec); end
        end
        n_tests++;
        if (state !== 2'd3 || fault !== 1'b1 || {high_z_a, high_z_b, high_z_c} !== 3'b111) begin
            n_fail++; $display("FAIL invalid_fault state=%0d fault=%b hz=%b exp 3 1 111", state, fault, {high_z_a, high_z_b, high_z_c});
        end
    endtask

    task automatic test_fault_clear();
        fault_clear = 1'b1; enable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            n_tests++;
            if (state !== 2'd3 || dut_vec !== exp_vec) begin n_fail++; $display("FAIL clear_needs_disable c=%0d state=%0d exp=3", c, state); end
        end
        enable = 1'b0;
        @(negedge clock);
        n_tests++;
        if (state !== 2'd0 || fault !== 1'b0 || dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL clear_exit state=%0d fault=%b exp 0 0", state, fault);
        end
        fault_clear = 1'b0; hall = 3'b101;
    endtask

    task automatic test_stall();
        int c_drive, c_fault, faults;
        enable = 1'b1; duty_cycle = 10'd100;
        c_drive = -1;
        for (int c = 0; c < 100 && c_drive < 0; c++) begin
            @(negedge clock);
            n_tests++;
            if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL stall_start c=%0d got=%h exp=%h", c, dut_vec, exp_vec); end
            if (state == 2'd2) c_drive = c;
        end
        c_fault = -1;
        for (int c = 1; c <= 400 && c_fault < 0; c++) begin
            @(negedge clock);
            n_tests++;
            if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL stall_run c=%0d got=%h exp=%h", c, dut_vec, exp_vec); end
            if (state == 2'd3) c_fault = c;
        end
        n_tests++;
        if (c_drive < 0 || c_fault != 255) begin n_fail++; $display("FAIL stall_timeout cycles=%0d exp=255", c_fault); end
        fault_clear = 1'b1; enable = 1'b0;
        @(negedge clock);
        fault_clear = 1'b0; duty_cycle = '0; enable = 1'b1;
        faults = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            n_tests++;
            if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL stall_zero c=%0d got=%h exp=%h", c, dut_vec, exp_vec); end
            if (state == 2'd3) faults++;
        end
        n_tests++;
        if (faults != 0 || state !== 2'd2) begin n_fail++; $display("FAIL stall_zero_duty fault_cycles=%0d state=%0d exp 0 2", faults, state); end
    endtask

    task automatic test_enable_drop();
        int seen;
        hall = 3'b100; seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clock);
            if (commutate) seen = 1;
        end
        repeat (3) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        n_tests++;
        if (seen == 0 || state !== 2'd0 || dut_vec !== RESET_VEC || dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL drop_in_dead seen=%0d state=%0d got=%h exp=%h", seen, state, dut_vec, RESET_VEC);
        end
        enable = 1'b1; duty_cycle = 10'd77; seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            @(negedge clock);
            if (state == 2'd2) seen = 1;
        end
        enable = 1'b0;
        @(negedge clock);
        n_tests++;
        if (seen == 0 || state !== 2'd0 || dut_vec !== RESET_VEC || dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL drop_in_drive seen=%0d state=%0d got=%h exp=%h", seen, state, dut_vec, RESET_VEC);
        end
    endtask

    task automatic test_async_reset();
        int seen;
        enable = 1'b1; duty_cycle = 10'd300; seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            @(negedge clock);
            if (state == 2'd2) seen = 1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (seen == 0 || dut_vec !== RESET_VEC) begin n_fail++; $display("FAIL async_reset seen=%0d got=%h exp=%h", seen, dut_vec, RESET_VEC); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int hold;
        logic [2:0] valid_codes [0:5];
        valid_codes = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                hall = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111)
                                                   : valid_codes[$urandom_range(0, 5)];
                hold = $urandom_range(1, 40);
            end
            hold--;
            if ($urandom_range(0, 99) == 0) direction = ~direction;
            if ($urandom_range(0, 7) == 0) duty_cycle = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom);
            enable      = ($urandom_range(0, 19) != 0);
            fault_clear = ($urandom_range(0, 3) == 0);
            @(negedge clock);
            n_tests++;
            if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, exp_vec); end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_walk(1'b0);
        test_walk(1'b1);
        test_glitch_fault();
        test_fault_clear();
        test_stall();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bldc_commutator.md
Name: bldc_commutator

Overview:
- Six-step (trapezoidal) commutation sequencer for one BLDC motor.
- Filters the three hall inputs and selects a per-phase role for each of the three phase drivers: PWM, LOW or FLOAT.
- Inserts a fixed dead interval, with all phases floating, at every commutation.
- Detects invalid hall codes and rotor stall, and latches a fault.

Parameters:
- DUTY_CYCLE_WIDTH, 10, width of duty_cycle and the per-phase duty outputs.
- HALL_FILTER, 4, consecutive stable synchronized samples (cycles) required to accept a new hall code; valid range 1..15.
- DEAD_TIME, 16, cycles all phases float between steps; valid range 1..255.
- STALL_WIDTH, 20, stall counter width; stall timeout is 2^STALL_WIDTH-1 cycles.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  run request; low forces IDLE.
- direction  input  1  0 = forward, 1 = reverse.
- duty_cycle  input  DUTY_CYCLE_WIDTH  commanded magnitude.
- hall  input  3  raw hall sensors {C,B,A}, asynchronous.
- fault_clear  input  1  fault acknowledge, level-sampled.
- duty_a, duty_b, duty_c  output  DUTY_CYCLE_WIDTH each  per-phase duty to the phase drivers.
- high_z_a, high_z_b, high_z_c  output  1 each  per-phase float to the phase drivers.
- commutate  output  1  one-cycle pulse when a DRIVE to DEAD transition occurs.
- fault  output  1  latched fault.
- state  output  2  IDLE=0, DEAD=1, DRIVE=2, FAULT=3.

Behaviour:
- Reset values: all outputs registered; all duty_* = 0, all high_z_* = 1, commutate = 0, fault = 0, state = IDLE, hall filter = 3'b000 (invalid).
- Hall path:
  - 2-FF synchronizer.
  - Filtered code updates only after the synchronized value has differed from the filtered code and held the same value for HALL_FILTER consecutive cycles.
  - The filter counter restarts on any change.
  - Codes 000 and 111 are invalid.
- Commutation table, forward (PWM phase / LOW phase / FLOAT phase):
  - 101: A / B / C
  - 100: A / C / B
  - 110: B / C / A
  - 010: B / A / C
  - 011: C / A / B
  - 001: C / B / A
- Reverse: the PWM and LOW roles are swapped; FLOAT is unchanged.
- Role encoding:
  - PWM: duty = registered duty_cycle, high_z = 0.
  - LOW: duty = 0, high_z = 0.
  - FLOAT: duty = 0, high_z = 1.
- IDLE:
  - All phases FLOAT.
  - When enable=1 and the filtered hall is valid, go to DEAD and load the dead counter with DEAD_TIME.
  - enable=1 with an invalid filtered hall stays in IDLE; it does not fault, which allows sensor power-up.
- DEAD:
  - All phases FLOAT; the counter decrements each cycle.
  - At 0, go to DRIVE using the role set for the current filtered hall and the current direction, and clear the stall counter.
  - enable=0 goes to IDLE.
  - An invalid hall goes to FAULT.
- DRIVE:
  - Outputs follow the table.
  - duty_cycle is resampled every cycle, with 1-cycle latency to the PWM phase.
  - A filtered-hall change to another valid code, or any direction change, goes to DEAD; commutate=1 on that edge.
  - enable=0 goes to IDLE, with outputs FLOAT on the next cycle.
  - An invalid filtered hall goes to FAULT.
  - Stall counter:
    - Increments each DRIVE cycle while duty_cycle != 0 and saturates.
    - Resets to 0 whenever duty_cycle == 0 or on entry to DRIVE.
    - Reaching all-ones goes to FAULT.
- FAULT:
  - All phases FLOAT; fault = 1.
  - Exit to IDLE only when fault_clear=1 and enable=0 in the same cycle.
- Priority within a cycle: reset > fault conditions > enable=0 > hall/direction change.
- Phase-driver output is never driven directly from one step's role set to the next; every change of role set passes through DEAD.
- Async reset mid-DRIVE: all phases FLOAT immediately.

Test Plan:
- Reset, enable=1, hall=101, forward, duty=512 → after 2+HALL_FILTER+1 cycles state=DEAD; 16 cycles later duty_a=512, high_z_a=0, duty_b=0, high_z_b=0, high_z_c=1.
- Walk hall through 101→100→110→010→011→001 at 200-cycle intervals → each step: commutate pulse, exactly 16 cycles all FLOAT, then roles per table; repeat with direction=1 and check PWM/LOW swapped.
- 2-cycle glitch 101→111→101 with HALL_FILTER=4 → no state change, no commutate; hold 111 for 4 cycles → FAULT, all high_z=1, fault=1.
- FAULT with fault_clear=1 and enable=1 → remains FAULT; then enable=0 with fault_clear=1 → IDLE, fault=0.
- STALL_WIDTH=8, duty=100, hall held at 101 → FAULT 255 cycles after DRIVE entry; repeat with duty=0 → no fault.
- enable dropped mid-DEAD and mid-DRIVE → IDLE next cycle, all FLOAT; reset_n low mid-DRIVE → outputs at reset values without waiting for a clock edge.
